// File: rtl/sliding_window_2d_pkg.sv
// rtl/sliding_window_2d_pkg.sv - shared pixel width, image defaults and window packing helpers
package sliding_window_2d_pkg;

    localparam int PIXEL_WIDTH        = 8;
    localparam int DEFAULT_IMG_WIDTH  = 640;
    localparam int DEFAULT_IMG_HEIGHT = 480;

    typedef enum logic {
        ST_FILL   = 1'b0,
        ST_STREAM = 1'b1
    } sw_state_e;

    // Bit offset of window element (i,j); i=0 is the top row, j=0 the left column.
    function automatic int win_offset(input int i, input int j, input int kernel_w, input int data_width);
        return (i * kernel_w + j) * data_width;
    endfunction

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sliding_window_2d_line_buffer.sv
// rtl/sliding_window_2d_line_buffer.sv - one image row of pixels, read-before-write at a single address
module sliding_window_2d_line_buffer
    import sliding_window_2d_pkg::*;
#(
    parameter int DATA_WIDTH = PIXEL_WIDTH,
    parameter int DEPTH      = DEFAULT_IMG_WIDTH,
    parameter int ADDR_WIDTH = cnt_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Asynchronous read returns the value from one row ago before the write lands.
    assign rdata_o = mem_q[addr_i];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

endmodule

// File: rtl/sliding_window_2d.sv
// rtl/sliding_window_2d.sv - raster pixel stream to KERNEL_H x KERNEL_W window stream
module sliding_window_2d
    import sliding_window_2d_pkg::*;
#(
    parameter int DATA_WIDTH = PIXEL_WIDTH,
    parameter int KERNEL_W   = 3,
    parameter int KERNEL_H   = 3,
    parameter int IMG_WIDTH  = DEFAULT_IMG_WIDTH,
    parameter int IMG_HEIGHT = DEFAULT_IMG_HEIGHT,
    parameter int OUT_WIDTH  = DATA_WIDTH * KERNEL_W * KERNEL_H
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    input  logic                  in_sof,
    output logic                  in_ready,
    output logic [OUT_WIDTH-1:0]  out_data,
    output logic                  out_valid,
    output logic                  out_last,
    input  logic                  out_ready
);

    localparam int CW   = cnt_width(IMG_WIDTH);
    localparam int RW   = cnt_width(IMG_HEIGHT);
    localparam int LB_N = (KERNEL_H > 1) ? KERNEL_H - 1 : 1;

    localparam logic [CW-1:0] COL_LAST      = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST      = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] COL_FIRST_WIN = CW'(KERNEL_W - 1);
    localparam logic [RW-1:0] ROW_STREAM    = RW'(KERNEL_H - 1);

    logic [CW-1:0]   col_q, col_d, pix_col;
    logic [RW-1:0]   row_q, row_d, pix_row;
    sw_state_e       state_q, state_d;
    logic            accept;
    logic            pix_stream, win_complete, win_last;
    logic            out_valid_q, out_valid_d;
    logic            out_last_q, out_last_d;

    logic [DATA_WIDTH-1:0] lb_rdata [LB_N];
    logic [DATA_WIDTH-1:0] col_vec  [KERNEL_H];
    logic [DATA_WIDTH-1:0] win_q    [KERNEL_H][KERNEL_W];

    assign in_ready  = !out_valid_q || out_ready;
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;

    // A start-of-frame pixel is (0,0) regardless of where the counters were.
    assign pix_col = in_sof ? '0 : col_q;
    assign pix_row = in_sof ? '0 : row_q;

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            if (pix_col == COL_LAST) begin
                col_d = '0;
                row_d = (pix_row == ROW_LAST) ? '0 : pix_row + 1'b1;
            end else begin
                col_d = pix_col + 1'b1;
                row_d = pix_row;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q   <= '0;
            row_q   <= '0;
            state_q <= ST_FILL;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            state_q <= state_d;
        end
    end

    // state_q describes the next pixel to arrive, so it is derived from its row.
    always_comb begin
        state_d = state_q;
        if (accept) begin
            state_d = (row_d >= ROW_STREAM) ? ST_STREAM : ST_FILL;
        end
    end

    always_comb begin
        pix_stream   = (KERNEL_H == 1) || (!in_sof && (state_q == ST_STREAM));
        win_complete = accept && pix_stream && (pix_col >= COL_FIRST_WIN);
        win_last     = win_complete && (pix_row == ROW_LAST) && (pix_col == COL_LAST);
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        if (accept) begin
            out_valid_d = win_complete;
            out_last_d  = win_last;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    generate
        if (KERNEL_H > 1) begin : g_lb
            for (genvar k = 0; k < KERNEL_H - 1; k++) begin : g_stage
                logic [DATA_WIDTH-1:0] wdata;
                if (k == 0) begin : g_head
                    assign wdata = in_data;
                end else begin : g_tail
                    assign wdata = lb_rdata[k-1];
                end
                sliding_window_2d_line_buffer #(
                    .DATA_WIDTH (DATA_WIDTH),
                    .DEPTH      (IMG_WIDTH),
                    .ADDR_WIDTH (CW)
                ) u_line_buffer (
                    .clk     (clk),
                    .we_i    (accept),
                    .addr_i  (pix_col),
                    .wdata_i (wdata),
                    .rdata_o (lb_rdata[k])
                );
            end
        end else begin : g_no_lb
            assign lb_rdata[0] = '0;
        end
    endgenerate

    // col_vec[0] is the oldest row; lb[0] holds the row directly above the new pixel.
    always_comb begin
        col_vec[KERNEL_H-1] = in_data;
        for (int k = 0; k < KERNEL_H - 1; k++) begin
            col_vec[KERNEL_H-2-k] = lb_rdata[k];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < KERNEL_H; i++) begin
                for (int j = 0; j < KERNEL_W; j++) begin
                    win_q[i][j] <= '0;
                end
            end
        end else if (accept) begin
            for (int i = 0; i < KERNEL_H; i++) begin
                for (int j = 0; j < KERNEL_W - 1; j++) begin
                    win_q[i][j] <= win_q[i][j+1];
                end
                win_q[i][KERNEL_W-1] <= col_vec[i];
            end
        end
    end

    always_comb begin
        out_data = '0;
        for (int i = 0; i < KERNEL_H; i++) begin
            for (int j = 0; j < KERNEL_W; j++) begin
                out_data[win_offset(i, j, KERNEL_W, DATA_WIDTH) +: DATA_WIDTH] = win_q[i][j];
            end
        end
    end

endmodule

// File: tb/tb_sliding_window_2d.sv
// tb/tb_sliding_window_2d.sv - directed scoreboard bench for a 3x3 and a 1x1 window on a 6x4 image
module tb_sliding_window_2d;

    localparam int DW   = 8;
    localparam int IW   = 6;
    localparam int IH   = 4;
    localparam int OW_A = DW * 9;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [DW-1:0]   in_data_a, in_data_b;
    logic            in_valid_a, in_sof_a, in_ready_a, out_valid_a, out_last_a, out_ready_a;
    logic            in_valid_b, in_sof_b, in_ready_b, out_valid_b, out_last_b, out_ready_b;
    logic [OW_A-1:0] out_data_a;
    logic [DW-1:0]   out_data_b;

    sliding_window_2d #(
        .DATA_WIDTH (DW), .KERNEL_W (3), .KERNEL_H (3), .IMG_WIDTH (IW), .IMG_HEIGHT (IH)
    ) u_dut_a (
        .clk (clk), .rst (rst),
        .in_data (in_data_a), .in_valid (in_valid_a), .in_sof (in_sof_a), .in_ready (in_ready_a),
        .out_data (out_data_a), .out_valid (out_valid_a), .out_last (out_last_a), .out_ready (out_ready_a)
    );

    sliding_window_2d #(
        .DATA_WIDTH (DW), .KERNEL_W (1), .KERNEL_H (1), .IMG_WIDTH (IW), .IMG_HEIGHT (IH)
    ) u_dut_b (
        .clk (clk), .rst (rst),
        .in_data (in_data_b), .in_valid (in_valid_b), .in_sof (in_sof_b), .in_ready (in_ready_b),
        .out_data (out_data_b), .out_valid (out_valid_b), .out_last (out_last_b), .out_ready (out_ready_b)
    );

    typedef struct packed {
        logic            last;
        logic [OW_A-1:0] data;
    } exp_t;

    exp_t sb_a[$];
    exp_t sb_b[$];

    int checks = 0;
    int errors = 0;
    int br[2];
    int bc[2];
    bit exp_valid[2];
    int win_cnt[2];
    int last_cnt[2];
    int cyc = 0;
    int acc22_cyc = -1;
    int first_win_cyc = -1;

    task automatic check(input string tag, input logic [OW_A-1:0] obs, input logic [OW_A-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [OW_A-1:0] exp_window(input int kh, input int kw, input int r, input int c);
        logic [OW_A-1:0] w;
        w = '0;
        for (int i = 0; i < kh; i++) begin
            for (int j = 0; j < kw; j++) begin
                w[(i*kw+j)*DW +: DW] = 8'((r - kh + 1 + i) * 16 + (c - kw + 1 + j));
            end
        end
        return w;
    endfunction

    task automatic idle_inputs();
        in_valid_a = 1'b0; in_sof_a = 1'b0; in_data_a = '0; out_ready_a = 1'b1;
        in_valid_b = 1'b0; in_sof_b = 1'b0; in_data_b = '0; out_ready_b = 1'b1;
    endtask

    // One clock of stimulus to DUT sel: check its outputs against the model, then advance the model.
    task automatic step(input int sel, input bit v, input bit sof, input bit rdy);
        logic [DW-1:0]   d;
        logic [OW_A-1:0] data_obs;
        logic            rdy_obs, val_obs, last_obs;
        int              pr, pc, k;
        bit              acc, complete;
        exp_t            e;
        @(negedge clk);
        k  = (sel == 0) ? 3 : 1;
        pr = sof ? 0 : br[sel];
        pc = sof ? 0 : bc[sel];
        d  = 8'(pr * 16 + pc);
        idle_inputs();
        if (sel == 0) begin
            in_valid_a = v; in_sof_a = sof; in_data_a = d; out_ready_a = rdy;
        end else begin
            in_valid_b = v; in_sof_b = sof; in_data_b = d; out_ready_b = rdy;
        end
        #1;
        if (sel == 0) begin
            rdy_obs = in_ready_a; val_obs = out_valid_a; last_obs = out_last_a; data_obs = out_data_a;
        end else begin
            rdy_obs = in_ready_b; val_obs = out_valid_b; last_obs = out_last_b; data_obs = OW_A'(out_data_b);
        end
        check("in_ready", OW_A'(rdy_obs), OW_A'(!exp_valid[sel] || rdy));
        check("out_valid", OW_A'(val_obs), OW_A'(exp_valid[sel]));
        if (exp_valid[sel]) begin
            e = (sel == 0) ? sb_a[0] : sb_b[0];
            check("out_data", data_obs, e.data);
            check("out_last", OW_A'(last_obs), OW_A'(e.last));
            if (rdy) begin
                if (sel == 0) void'(sb_a.pop_front()); else void'(sb_b.pop_front());
                win_cnt[sel]++;
                if (e.last) last_cnt[sel]++;
                if (sel == 0 && first_win_cyc < 0) first_win_cyc = cyc;
            end
        end else begin
            check("out_last_idle", OW_A'(last_obs), '0);
        end
        acc = v && (!exp_valid[sel] || rdy);
        if (acc) begin
            complete = (pr >= k - 1) && (pc >= k - 1);
            if (complete) begin
                e.data = exp_window(k, k, pr, pc);
                e.last = (pr == IH - 1) && (pc == IW - 1);
                if (sel == 0) sb_a.push_back(e); else sb_b.push_back(e);
            end
            if (sel == 0 && pr == 2 && pc == 2 && acc22_cyc < 0) acc22_cyc = cyc;
            exp_valid[sel] = complete;
            if (pc == IW - 1) begin
                bc[sel] = 0;
                br[sel] = (pr == IH - 1) ? 0 : pr + 1;
            end else begin
                bc[sel] = pc + 1;
                br[sel] = pr;
            end
        end else if (rdy) begin
            exp_valid[sel] = 1'b0;
        end
        cyc++;
    endtask

    task automatic run_frame(input int sel, input bit with_sof, input int exp_windows, input string tag);
        win_cnt[sel]  = 0;
        last_cnt[sel] = 0;
        for (int p = 0; p < IW * IH; p++) step(sel, 1'b1, with_sof && (p == 0), 1'b1);
        step(sel, 1'b0, 1'b0, 1'b1);
        check({tag, "_windows"}, OW_A'(win_cnt[sel]), OW_A'(exp_windows));
        check({tag, "_last"}, OW_A'(last_cnt[sel]), OW_A'(1));
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            br[s] = 0; bc[s] = 0; exp_valid[s] = 1'b0; win_cnt[s] = 0; last_cnt[s] = 0;
        end
        rst = 1'b1;
        idle_inputs();
        #2;
        check("reset_valid_a", OW_A'(out_valid_a), '0);
        check("reset_last_a", OW_A'(out_last_a), '0);
        check("reset_data_a", out_data_a, '0);
        check("reset_ready_a", OW_A'(in_ready_a), OW_A'(1));
        check("reset_valid_b", OW_A'(out_valid_b), '0);
        check("reset_data_b", OW_A'(out_data_b), '0);
        @(negedge clk);
        rst = 1'b0;

        run_frame(0, 1'b1, 8, "frame1");
        check("first_window_latency", OW_A'(first_win_cyc), OW_A'(acc22_cyc + 1));

        // Second frame by counter wrap, stalled right after the window anchored at 0x22.
        win_cnt[0] = 0; last_cnt[0] = 0;
        for (int p = 0; p < 15; p++) step(0, 1'b1, 1'b0, 1'b1);
        for (int s = 0; s < 5; s++) step(0, 1'b1, 1'b0, 1'b0);
        for (int p = 15; p < IW * IH; p++) step(0, 1'b1, 1'b0, 1'b1);
        step(0, 1'b0, 1'b0, 1'b1);
        check("backpressure_windows", OW_A'(win_cnt[0]), OW_A'(8));
        check("backpressure_last", OW_A'(last_cnt[0]), OW_A'(1));

        // Resync: sof lands on nominal (2,3) and restarts the frame there.
        for (int p = 0; p < 15; p++) step(0, 1'b1, 1'b0, 1'b1);
        step(0, 1'b1, 1'b1, 1'b1);
        win_cnt[0] = 0; last_cnt[0] = 0;
        for (int p = 1; p < IW * IH; p++) step(0, 1'b1, 1'b0, 1'b1);
        step(0, 1'b0, 1'b0, 1'b1);
        check("resync_windows", OW_A'(win_cnt[0]), OW_A'(8));
        check("resync_last", OW_A'(last_cnt[0]), OW_A'(1));
        run_frame(0, 1'b1, 8, "back_to_back");

        // Asynchronous reset while a window is held by backpressure.
        for (int p = 0; p < 15; p++) step(0, 1'b1, 1'b0, 1'b1);
        step(0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        check("midreset_valid", OW_A'(out_valid_a), '0);
        check("midreset_last", OW_A'(out_last_a), '0);
        check("midreset_data", out_data_a, '0);
        check("midreset_ready", OW_A'(in_ready_a), OW_A'(1));
        br[0] = 0; bc[0] = 0; exp_valid[0] = 1'b0;
        sb_a.delete();
        @(negedge clk);
        rst = 1'b0;
        run_frame(0, 1'b0, 8, "after_reset");

        run_frame(1, 1'b1, IW * IH, "degenerate");
        run_frame(1, 1'b0, IW * IH, "degenerate_wrap");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
